// File: rtl/regfile_banked.sv
// Banked integer register file for the ID stage.
// NUM_BANKS shadow banks give zero-copy interrupt context switching: the bank
// index is the interrupt nesting level, pushed on entry and popped on mret.
// NUM_RD combinational read ports see same-cycle writes through a bypass.
// There are two write ports; port 0 wins when both target the same address.
module regfile_banked #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_BANKS  = 2,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    input  logic                         wr0_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr0_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr0_data_i,
    input  logic                         wr1_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr1_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr1_data_i,
    input  logic                         bank_push_i,
    input  logic                         bank_pop_i,
    output logic [BANK_W-1:0]            cur_bank_o,
    output logic [1:0]                   bank_err_o
);

    // Storage for every bank; entry 0 of each bank is reset to zero and never written.
    logic [DATA_WIDTH-1:0] regs [NUM_BANKS][DEPTH];

    logic [BANK_W-1:0] cur_bank;
    logic [1:0]        bank_err;   // {underflow, overflow}

    logic wr0_ok;
    logic wr1_ok;
    logic at_top;
    logic at_bottom;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;

    // An address is storable when it is non-zero and inside the bank.
    function automatic logic addr_storable(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] wide;
        wide = {1'b0, addr};
        return (addr != '0) && (wide < (ADDR_WIDTH+1)'(DEPTH));
    endfunction

    // Port 1 is dropped silently whenever port 0 claims the same address.
    assign wr0_ok = wr0_en_i && addr_storable(wr0_addr_i);
    assign wr1_ok = wr1_en_i && addr_storable(wr1_addr_i)
                    && !(wr0_en_i && (wr0_addr_i == wr1_addr_i));

    assign at_top    = (cur_bank == BANK_W'(NUM_BANKS - 1));
    assign at_bottom = (cur_bank == '0);

    // Register writes land in the bank selected before any same-cycle switch.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < DEPTH; r++) begin
                    regs[b][r] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 1; r < DEPTH; r++) begin
                    if (cur_bank == BANK_W'(b)) begin
                        if (wr0_ok && (wr0_addr_i == ADDR_WIDTH'(r))) begin
                            regs[b][r] <= wr0_data_i;
                        end else if (wr1_ok && (wr1_addr_i == ADDR_WIDTH'(r))) begin
                            regs[b][r] <= wr1_data_i;
                        end
                    end
                end
            end
        end
    end

    // Bank nesting level: push/pop move it, saturating at the ends with sticky errors.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cur_bank <= '0;
            bank_err <= 2'b00;
        end else begin
            case ({bank_push_i, bank_pop_i})
                2'b10: begin
                    if (at_top) begin
                        bank_err[0] <= 1'b1;
                    end else begin
                        cur_bank <= cur_bank + BANK_W'(1);
                    end
                end
                2'b01: begin
                    if (at_bottom) begin
                        bank_err[1] <= 1'b1;
                    end else begin
                        cur_bank <= cur_bank - BANK_W'(1);
                    end
                end
                // Push and pop together is a tail-chained interrupt: level stays put.
                default: begin
                    cur_bank <= cur_bank;
                end
            endcase
        end
    end

    // Read ports: x0 is zero, then port 0 bypass, then port 1 bypass, then storage.
    always_comb begin
        rd_data = '0;
        rd_addr = '0;
        rd_word = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr = rd_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_word = '0;
            if (!resetn_i || (rd_addr == '0)) begin
                rd_word = '0;
            end else if (wr0_en_i && (wr0_addr_i == rd_addr)) begin
                rd_word = wr0_data_i;
            end else if (wr1_en_i && (wr1_addr_i == rd_addr)) begin
                rd_word = wr1_data_i;
            end else begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    for (int r = 1; r < DEPTH; r++) begin
                        if ((cur_bank == BANK_W'(b)) && (rd_addr == ADDR_WIDTH'(r))) begin
                            rd_word = regs[b][r];
                        end
                    end
                end
            end
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_word;
        end
    end

    assign rd_data_o  = rd_data;
    assign cur_bank_o = cur_bank;
    assign bank_err_o = bank_err;

endmodule

// File: tb/tb_regfile_banked.sv
// Bench for regfile_banked: directed vectors with literal expectations plus a
// behavioural model of the register file compared on every falling clock edge.
module tb_regfile_banked;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NB = 2;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic            wr0_en = 1'b0;
    logic [AW-1:0]   wr0_addr = '0;
    logic [DW-1:0]   wr0_data = '0;
    logic            wr1_en = 1'b0;
    logic [AW-1:0]   wr1_addr = '0;
    logic [DW-1:0]   wr1_data = '0;
    logic            push = 1'b0;
    logic            pop = 1'b0;
    logic [0:0]      cur_bank;
    logic [1:0]      bank_err;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // Model state: plain arrays and an integer nesting level.
    bit [31:0] mreg [NB][32];
    int        mlvl = 0;
    bit [1:0]  merr = 2'b00;
    int        mnext;
    int        mb;

    regfile_banked #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32), .NUM_RD(NR), .NUM_BANKS(NB)
    ) dut (
        .clk_i(clk),
        .resetn_i(resetn),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .wr0_en_i(wr0_en),
        .wr0_addr_i(wr0_addr),
        .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en),
        .wr1_addr_i(wr1_addr),
        .wr1_data_i(wr1_data),
        .bank_push_i(push),
        .bank_pop_i(pop),
        .cur_bank_o(cur_bank),
        .bank_err_o(bank_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected value of a read port given the current inputs and model state.
    function automatic bit [31:0] model_read(input logic [AW-1:0] a);
        if (resetn !== 1'b1) return 32'h0;
        if (a == 0) return 32'h0;
        if (wr0_en && wr0_addr == a) return wr0_data;
        if (wr1_en && wr1_addr == a) return wr1_data;
        return mreg[mlvl][a];
    endfunction

    // Model update: port 1 applied first so port 0 naturally overrides it.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < 32; r++)
                    mreg[b][r] = 32'h0;
            mlvl = 0;
            merr = 2'b00;
        end else begin
            mb = mlvl;
            if (wr1_en && wr1_addr != 0) mreg[mb][wr1_addr] = wr1_data;
            if (wr0_en && wr0_addr != 0) mreg[mb][wr0_addr] = wr0_data;
            mnext = mlvl + int'(push) - int'(pop);
            if (mnext > NB - 1) merr[0] = 1'b1;
            else if (mnext < 0) merr[1] = 1'b1;
            else mlvl = mnext;
        end
    end

    // Continuous comparison against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NR; k++)
                check($sformatf("model rd%0d", k), rd_data[k*DW +: DW],
                      model_read(rd_addr[k*AW +: AW]));
            check("model cur_bank", 32'(cur_bank), 32'(mlvl));
            check("model bank_err", 32'(bank_err), 32'(merr));
        end
    end

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        idle();
        set_rd(5'd5, 5'd7);
        #2 resetn = 1'b0;
        chk_on = 1'b1;
        #1;
        check("reset rd0", rd_data[31:0], 32'h0);
        check("reset bank", 32'(cur_bank), 32'h0);
        check("reset err", 32'(bank_err), 32'h0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // 1: write then read back, x0 reads zero
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        tick(); idle();
        set_rd(5'd5, 5'd0); #1;
        check("t1 x5", rd_data[31:0], 32'hDEADBEEF);
        check("t1 x0", rd_data[63:32], 32'h0);
        tick();

        // 2: both ports to x7, port 0 wins in bypass and in storage
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        set_rd(5'd7, 5'd5); #1;
        check("t2 bypass x7", rd_data[31:0], 32'h11);
        tick(); idle(); #1;
        check("t2 stored x7", rd_data[31:0], 32'h11);
        tick();

        // 2b: distinct addresses both written
        wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'hAAAA0001;
        wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'hBBBB0002;
        tick(); idle();
        set_rd(5'd10, 5'd11); #1;
        check("t2b x10", rd_data[31:0], 32'hAAAA0001);
        check("t2b x11", rd_data[63:32], 32'hBBBB0002);
        tick();

        // 3: port 1 bypass on read port 1; x0 never written
        wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'hA5A5;
        set_rd(5'd0, 5'd3); #1;
        check("t3 bypass x3", rd_data[63:32], 32'hA5A5);
        tick(); idle();
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        #1;
        check("t3 x0 same cycle", rd_data[31:0], 32'h0);
        tick(); idle(); #1;
        check("t3 x0 after", rd_data[31:0], 32'h0);
        check("t3 x3 stored", rd_data[63:32], 32'hA5A5);
        tick();

        // 4: shadow bank holds its own x2
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h100;
        tick(); idle();
        push = 1'b1;
        tick(); idle(); #1;
        check("t4 bank after push", 32'(cur_bank), 32'h1);
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h200;
        tick(); idle();
        set_rd(5'd2, 5'd5); #1;
        check("t4 bank1 x2", rd_data[31:0], 32'h200);
        check("t4 bank1 x5", rd_data[63:32], 32'h0);
        pop = 1'b1;
        tick(); idle(); #1;
        check("t4 bank0 x2", rd_data[31:0], 32'h100);
        check("t4 bank after pop", 32'(cur_bank), 32'h0);
        tick();

        // 5: tail-chain at both levels, then overflow and underflow
        push = 1'b1; pop = 1'b1;
        tick(); idle(); #1;
        check("t5 chain bank0", 32'(cur_bank), 32'h0);
        check("t5 chain err0", 32'(bank_err), 32'h0);
        push = 1'b1; tick(); idle();
        push = 1'b1; pop = 1'b1; tick(); idle(); #1;
        check("t5 chain bank1", 32'(cur_bank), 32'h1);
        check("t5 chain err1", 32'(bank_err), 32'h0);
        push = 1'b1; tick(); idle(); #1;
        check("t5 overflow bank", 32'(cur_bank), 32'h1);
        check("t5 overflow err", 32'(bank_err), 32'h1);
        pop = 1'b1; tick();
        pop = 1'b1; tick(); idle(); #1;
        check("t5 underflow bank", 32'(cur_bank), 32'h0);
        check("t5 underflow err", 32'(bank_err), 32'h3);
        tick();

        // 6: write lands in old bank during a push; bank 1 keeps its own value
        push = 1'b1;
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h55;
        tick(); idle();
        set_rd(5'd9, 5'd2); #1;
        check("t6 bank1 x9", rd_data[31:0], 32'h0);
        check("t6 bank1 x2 kept", rd_data[63:32], 32'h200);
        pop = 1'b1;
        tick(); idle(); #1;
        check("t6 bank0 x9", rd_data[31:0], 32'h55);
        push = 1'b1;
        tick(); idle();

        // 6b: reset mid-cycle with a write and a pop pending
        wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h77;
        pop = 1'b1;
        set_rd(5'd9, 5'd2);
        #2 resetn = 1'b0;
        #1;
        check("t6 rst rd0", rd_data[31:0], 32'h0);
        check("t6 rst rd1", rd_data[63:32], 32'h0);
        check("t6 rst bank", 32'(cur_bank), 32'h0);
        check("t6 rst err", 32'(bank_err), 32'h0);
        tick(); idle(); tick();
        resetn = 1'b1;
        set_rd(5'd5, 5'd9); #1;
        check("t6 cleared x5", rd_data[31:0], 32'h0);
        check("t6 cleared x9", rd_data[63:32], 32'h0);
        tick(); tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
